mem_port_arbiter: RTL and testbench

//  Shares port A of the single-port synchronous RAM between three requesters:

---
 rtl/kanade32_mem_pkg.sv | 25 ++
 rtl/mem_arb_starve_ctr.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kanade32_mem_pkg.sv
// ----------------------------------------------------------------------------
// kanade32_mem_pkg
//   Shared definitions for the RAM port A arbiter slice: word-address width,
//   requester identifiers and arbiter FSM states.
// ----------------------------------------------------------------------------
package kanade32_mem_pkg;

    // RAM word address width (32-bit words, 4 GiB byte space)
    localparam int unsigned WADDR_W = 30;

    // Requester identity, also used as the read-data owner tag
    typedef enum logic [1:0] {
        REQ_NONE   = 2'd0,
        REQ_DATA   = 2'd1,
        REQ_FETCH  = 2'd2,
        REQ_LOADER = 2'd3
    } req_id_e;

    // Arbiter FSM states
    typedef enum logic {
        ARB_ST_ARB    = 1'b0,
        ARB_ST_LOCKED = 1'b1
    } arb_state_e;

endpackage : kanade32_mem_pkg

// File: rtl/mem_arb_starve_ctr.sv
// ----------------------------------------------------------------------------
// mem_arb_starve_ctr
//   Saturating starvation counter for the loader requester.
//   Ports:
//     clk, reset  clock and synchronous active-high reset
//     inc         count one more waiting cycle (saturates at LIMIT)
//     clr         clear the count (has priority over inc)
//     at_limit    count has reached LIMIT
// ----------------------------------------------------------------------------
module mem_arb_starve_ctr #(
    parameter int unsigned LIMIT = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == LIMIT_C);

endmodule : mem_arb_starve_ctr

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares port A of the single-port synchronous RAM between the data (MW)
//   requester, instruction fetch and the boot/debug loader. One grant per
//   cycle, combinational within the request cycle; the 1-cycle-latency read
//   data is tagged back to its owner with a one-cycle *_rvalid strobe.
//   Ports:
//     clk, reset                    clock, synchronous active-high reset
//     d_req/d_addr/d_we/d_byteen/d_wdata -> d_gnt, d_rvalid   data access
//     f_req/f_addr                  -> f_gnt, f_rvalid        fetch (read only)
//     l_req/l_lock/l_addr/l_we/l_byteen/l_wdata -> l_gnt, l_rvalid  loader
//     rdata                         shared read data (= ram_q)
//     ram_addr/ram_wren/ram_byteen/ram_wdata, ram_q   RAM port A
// ----------------------------------------------------------------------------
module mem_port_arbiter
    import kanade32_mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned CNT_W        = 4
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               d_req,
    input  logic [WADDR_W-1:0] d_addr,
    input  logic               d_we,
    input  logic [3:0]         d_byteen,
    input  logic [31:0]        d_wdata,
    output logic               d_gnt,
    output logic               d_rvalid,

    input  logic               f_req,
    input  logic [WADDR_W-1:0] f_addr,
    output logic               f_gnt,
    output logic               f_rvalid,

    input  logic               l_req,
    input  logic               l_lock,
    input  logic [WADDR_W-1:0] l_addr,
    input  logic               l_we,
    input  logic [3:0]         l_byteen,
    input  logic [31:0]        l_wdata,
    output logic               l_gnt,
    output logic               l_rvalid,

    output logic [31:0]        rdata,

    output logic [WADDR_W-1:0] ram_addr,
    output logic               ram_wren,
    output logic [3:0]         ram_byteen,
    output logic [31:0]        ram_wdata,
    input  logic [31:0]        ram_q
);

    arb_state_e state_q, state_d;
    req_id_e    owner_q, owner_d;
    req_id_e    win;
    logic       starve_at_limit;

    // ------------------------------------------------------------------
    // Winner selection. A loader that is locked or starved pre-empts
    // everyone; otherwise fixed priority data > fetch > loader.
    // Nothing is granted while reset is held.
    // ------------------------------------------------------------------
    always_comb begin
        win = REQ_NONE;
        if (!reset) begin
            if (l_req && ((state_q == ARB_ST_LOCKED) || starve_at_limit)) begin
                win = REQ_LOADER;
            end else if (d_req) begin
                win = REQ_DATA;
            end else if (f_req) begin
                win = REQ_FETCH;
            end else if (l_req) begin
                win = REQ_LOADER;
            end
        end
    end

    assign d_gnt = (win == REQ_DATA);
    assign f_gnt = (win == REQ_FETCH);
    assign l_gnt = (win == REQ_LOADER);

    // RAM port follows the winner; reads enable all bytes and drive zero data
    always_comb begin
        ram_addr   = '0;
        ram_wren   = 1'b0;
        ram_byteen = '0;
        ram_wdata  = '0;
        case (win)
            REQ_DATA: begin
                ram_addr   = d_addr;
                ram_wren   = d_we;
                ram_byteen = d_we ? d_byteen : '1;
                ram_wdata  = d_we ? d_wdata  : '0;
            end
            REQ_FETCH: begin
                ram_addr   = f_addr;
                ram_byteen = '1;
            end
            REQ_LOADER: begin
                ram_addr   = l_addr;
                ram_wren   = l_we;
                ram_byteen = l_we ? l_byteen : '1;
                ram_wdata  = l_we ? l_wdata  : '0;
            end
            default: ;
        endcase
    end

    // Next state / owner
    always_comb begin
        state_d = state_q;
        if (l_gnt) begin
            state_d = l_lock ? ARB_ST_LOCKED : ARB_ST_ARB;
        end else if (!l_req) begin
            state_d = ARB_ST_ARB;
        end

        owner_d = REQ_NONE;
        if ((win != REQ_NONE) && !ram_wren) begin
            owner_d = win;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_ST_ARB;
            owner_q <= REQ_NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    mem_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT),
        .CNT_W (CNT_W)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .inc      (l_req && !l_gnt),
        .clr      (l_gnt || !l_req),
        .at_limit (starve_at_limit)
    );

    // Reset is synchronous, so owner_q still holds last cycle's tag during
    // the first reset cycle; gate the strobes so reset silences them at once.
    assign d_rvalid = (owner_q == REQ_DATA)   && !reset;
    assign f_rvalid = (owner_q == REQ_FETCH)  && !reset;
    assign l_rvalid = (owner_q == REQ_LOADER) && !reset;

    assign rdata = ram_q;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter with a behavioural RAM and a
//   read-data scoreboard.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        d_req, d_we, f_req, l_req, l_lock, l_we;
    logic [29:0] d_addr, f_addr, l_addr;
    logic [3:0]  d_byteen, l_byteen;
    logic [31:0] d_wdata, l_wdata;
    logic        d_gnt, d_rvalid, f_gnt, f_rvalid, l_gnt, l_rvalid;
    logic [31:0] rdata;
    logic [29:0] ram_addr;
    logic        ram_wren;
    logic [3:0]  ram_byteen;
    logic [31:0] ram_wdata;
    logic [31:0] ram_q;

    mem_port_arbiter #(
        .STARVE_LIMIT (8),
        .CNT_W        (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .d_req      (d_req),
        .d_addr     (d_addr),
        .d_we       (d_we),
        .d_byteen   (d_byteen),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .f_req      (f_req),
        .f_addr     (f_addr),
        .f_gnt      (f_gnt),
        .f_rvalid   (f_rvalid),
        .l_req      (l_req),
        .l_lock     (l_lock),
        .l_addr     (l_addr),
        .l_we       (l_we),
        .l_byteen   (l_byteen),
        .l_wdata    (l_wdata),
        .l_gnt      (l_gnt),
        .l_rvalid   (l_rvalid),
        .rdata      (rdata),
        .ram_addr   (ram_addr),
        .ram_wren   (ram_wren),
        .ram_byteen (ram_byteen),
        .ram_wdata  (ram_wdata),
        .ram_q      (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    // Behavioural RAM: stores the difference from the power-up pattern so
    // the zero-initialised bit array needs no separate initialisation.
    bit [31:0] ram_mem [0:1023];
    always @(posedge clk) begin : ram_model
        logic [9:0]  ix;
        logic [31:0] iw;
        ix = ram_addr[9:0];
        iw = init_word(int'(ix));
        if (ram_wren)
            for (int b = 0; b < 4; b++)
                if (ram_byteen[b]) ram_mem[ix][b*8 +: 8] <= ram_wdata[b*8 +: 8] ^ iw[b*8 +: 8];
        ram_q <= ram_mem[ix] ^ iw;
    end

    // Expected memory contents, maintained from the stimulus side only
    logic [31:0] exp_mem [0:1023];

    typedef struct {
        int          due;
        logic [2:0]  rv;
        logic [31:0] data;
    } sb_t;
    sb_t sb_q[$];

    // Read-return monitor: exactly the scheduled strobe (or none) each cycle
    always @(negedge clk) begin : monitor
        logic [2:0]  erv;
        logic [31:0] edata;
        erv   = '0;
        edata = '0;
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            erv   = sb_q[0].rv;
            edata = sb_q[0].data;
            void'(sb_q.pop_front());
        end
        if (reset) erv = '0;
        check_eq("rvalid", 72'({d_rvalid, f_rvalid, l_rvalid}), 72'(erv));
        if (erv != 3'b000) check_eq("rdata", 72'(rdata), 72'(edata));
        check_eq("gnt_onehot0", 72'($onehot0({d_gnt, f_gnt, l_gnt})), 72'(1'b1));
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_reqs();
        d_req  = 1'b0; f_req = 1'b0; l_req = 1'b0;
        l_lock = 1'b0; d_we  = 1'b0; l_we  = 1'b0;
    endtask

    // who: 0 none, 1 data, 2 fetch, 3 loader
    task automatic expect_grant(input string tag, input int who);
        logic [2:0]  eg;
        logic [29:0] a;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
        eg = '0; a = '0; we = 1'b0; be = '0; wd = '0;
        case (who)
            1: begin eg = 3'b100; a = d_addr; we = d_we;
                     be = d_we ? d_byteen : 4'hF; wd = d_we ? d_wdata : 32'h0; end
            2: begin eg = 3'b010; a = f_addr; be = 4'hF; end
            3: begin eg = 3'b001; a = l_addr; we = l_we;
                     be = l_we ? l_byteen : 4'hF; wd = l_we ? l_wdata : 32'h0; end
            default: ;
        endcase
        @(negedge clk);
        check_eq({tag, "_gnt"}, 72'({d_gnt, f_gnt, l_gnt}), 72'(eg));
        check_eq({tag, "_ram"}, 72'({ram_addr, ram_wren, ram_byteen, ram_wdata}),
                 72'({a, we, be, wd}));
        if (who != 0 && !reset) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) exp_mem[a[9:0]][b*8 +: 8] = wd[b*8 +: 8];
            end else begin
                sb_q.push_back('{due: cyc + 1, rv: eg, data: exp_mem[a[9:0]]});
            end
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        for (int i = 0; i < 1024; i++) exp_mem[i] = init_word(i);

        reset    = 1'b1;
        d_req    = 1'b1; d_addr = 30'h10; d_we = 1'b0; d_byteen = 4'h0; d_wdata = 32'h0;
        f_req    = 1'b1; f_addr = 30'h40;
        l_req    = 1'b1; l_lock = 1'b0; l_addr = 30'h50; l_we = 1'b0;
        l_byteen = 4'h0; l_wdata = 32'h0;

        // Reset held with every requester active: nothing granted
        repeat (2) expect_grant("rst", 0);

        // First cycle out of reset: data wins, read of 0x10
        next_cycle();
        reset = 1'b0;
        expect_grant("first", 1);
        check_eq("first_state", 72'(dut.state_q), 72'(0));

        next_cycle();
        idle_reqs();
        expect_grant("idle", 0);

        // Starvation: fetch keeps winning until the loader is forced in
        for (int i = 0; i < 9; i++) begin
            next_cycle();
            f_req  = 1'b1; f_addr = 30'h40 + 30'(i);
            l_req  = 1'b1; l_addr = 30'h50; l_we = 1'b0; l_lock = 1'b0;
            expect_grant("starve", (i < 8) ? 2 : 3);
            check_eq("starve_cnt", 72'(dut.u_starve.cnt_q), 72'(i));
        end
        next_cycle();
        idle_reqs();
        expect_grant("post_starve", 0);
        check_eq("starve_cnt_clr", 72'(dut.u_starve.cnt_q), 72'(0));

        // Locked loader burst of writes with data requesting alongside
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            l_req    = 1'b1; l_we = 1'b1; l_lock = (k != 3);
            l_addr   = 30'h100 + 30'(k); l_byteen = 4'hF;
            l_wdata  = 32'hA500_0000 | 32'(k);
            d_req    = (k != 0); d_addr = 30'h11; d_we = 1'b0;
            expect_grant("lock", 3);
            check_eq("lock_state", 72'(dut.state_q), 72'((k == 0) ? 0 : 1));
        end
        next_cycle();
        l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0;
        d_req = 1'b1;
        expect_grant("after_lock", 1);
        check_eq("unlock_state", 72'(dut.state_q), 72'(0));

        // Read back one burst word through fetch
        next_cycle();
        d_req = 1'b0; f_req = 1'b1; f_addr = 30'h102;
        expect_grant("rb_lock", 2);

        // Single-byte data write, then read it back
        next_cycle();
        f_req = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 30'h20; d_byteen = 4'b0100; d_wdata = 32'h00AB_0000;
        expect_grant("bytewr", 1);
        next_cycle();
        d_we = 1'b0; d_byteen = 4'h0; d_wdata = 32'h0;
        expect_grant("bytewr_rd", 1);
        next_cycle();
        idle_reqs();
        expect_grant("idle2", 0);
        check_eq("bytewr_model", 72'(exp_mem[32]), 72'(32'hC0AB_0020));

        // Reset lands on the cycle that would return a fetch read
        next_cycle();
        f_req = 1'b1; f_addr = 30'h30; l_req = 1'b1; l_we = 1'b0; l_addr = 30'h50;
        expect_grant("pre_rst", 2);
        check_eq("pre_rst_cnt", 72'(dut.u_starve.cnt_q), 72'(0));
        next_cycle();
        reset = 1'b1; f_req = 1'b0;
        expect_grant("rst_mid", 0);
        next_cycle();
        reset = 1'b0; idle_reqs();
        expect_grant("post_rst", 0);
        check_eq("post_rst_state", 72'(dut.state_q), 72'(0));
        check_eq("post_rst_cnt", 72'(dut.u_starve.cnt_q), 72'(0));

        next_cycle();
        expect_grant("tail", 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mem_port_arbiter
